// File: rtl/ibex_wb_port_arbiter.sv
// Shares the single register-file write slot among LSU, ID/EX and multi-cycle producers; one-entry EX skid buffer.
// Latency: direct grants write combinationally in the request cycle; a skid-buffered EX result writes one or more cycles later.
// Backpressure: the LSU is never stalled; EX stalls only while the skid is full; the multi-cycle unit waits for mc_ready_o.
module ibex_wb_port_arbiter #(
    parameter int FPU_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_valid_i,
    input  logic                 lsu_fp_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [31:0]          lsu_wdata_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic                 ex_fp_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [FPU_WIDTH-1:0] ex_wdata_i,
    input  logic                 mc_valid_i,
    output logic                 mc_ready_o,
    input  logic                 mc_fp_i,
    input  logic [4:0]           mc_waddr_i,
    input  logic [FPU_WIDTH-1:0] mc_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic                 fp_rf_we_o,
    output logic [4:0]           fp_rf_waddr_o,
    output logic [FPU_WIDTH-1:0] fp_rf_wdata_o,
    output logic                 pending_o,
    output logic                 pending_fp_o,
    output logic [4:0]           pending_waddr_o,
    output logic                 perf_stall_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                 skid_valid_q;
    logic                 skid_fp_q;
    logic [4:0]           skid_waddr_q;
    logic [FPU_WIDTH-1:0] skid_wdata_q;
    logic [3:0]           starve_cnt_q;

    logic                 cand_vld;
    logic                 cand_fp;
    logic [4:0]           cand_waddr;
    logic [FPU_WIDTH-1:0] cand_wdata;
    logic                 at_limit;
    logic                 gnt_lsu;
    logic                 gnt_ex;
    logic                 gnt_mc;
    logic                 any_gnt;
    logic                 ex_hs;
    logic [FPU_WIDTH-1:0] lsu_fp_data;
    logic                 sel_fp;
    logic [4:0]           sel_addr;
    logic [FPU_WIDTH-1:0] sel_data;

    // FP loads into a 64-bit file must be NaN-boxed single-precision values.
    if (FPU_WIDTH == 64) begin : g_nanbox
        assign lsu_fp_data = {32'hFFFF_FFFF, lsu_wdata_i};
    end else begin : g_pass
        assign lsu_fp_data = lsu_wdata_i;
    end

    // The skid entry, when present, always stands in for the EX port.
    assign cand_vld   = skid_valid_q | ex_valid_i;
    assign cand_fp    = skid_valid_q ? skid_fp_q    : ex_fp_i;
    assign cand_waddr = skid_valid_q ? skid_waddr_q : ex_waddr_i;
    assign cand_wdata = skid_valid_q ? skid_wdata_q : ex_wdata_i;

    assign at_limit = (starve_cnt_q == LIMIT);
    assign gnt_lsu  = rst_ni & lsu_valid_i;
    assign gnt_ex   = rst_ni & ~lsu_valid_i & cand_vld & ~(at_limit & mc_valid_i);
    assign gnt_mc   = rst_ni & ~lsu_valid_i & mc_valid_i & (~cand_vld | at_limit);
    assign any_gnt  = gnt_lsu | gnt_ex | gnt_mc;
    assign ex_hs    = ex_valid_i & ~skid_valid_q;

    assign ex_ready_o      = ~skid_valid_q;
    assign mc_ready_o      = gnt_mc;
    assign pending_o       = skid_valid_q;
    assign pending_fp_o    = skid_valid_q & skid_fp_q;
    assign pending_waddr_o = skid_valid_q ? skid_waddr_q : 5'd0;
    assign perf_stall_o    = rst_ni & ((lsu_valid_i & (cand_vld | mc_valid_i)) | (cand_vld & mc_valid_i));

    always_comb begin
        sel_fp   = 1'b0;
        sel_addr = 5'd0;
        sel_data = '0;
        if (gnt_lsu) begin
            sel_fp   = lsu_fp_i;
            sel_addr = lsu_waddr_i;
            sel_data = lsu_fp_i ? lsu_fp_data : FPU_WIDTH'(lsu_wdata_i);
        end else if (gnt_ex) begin
            sel_fp   = cand_fp;
            sel_addr = cand_waddr;
            sel_data = cand_wdata;
        end else if (gnt_mc) begin
            sel_fp   = mc_fp_i;
            sel_addr = mc_waddr_i;
            sel_data = mc_wdata_i;
        end
    end

    // x0 writes are consumed by the grant but never reach the integer file.
    always_comb begin
        rf_we_o       = 1'b0;
        rf_waddr_o    = 5'd0;
        rf_wdata_o    = 32'd0;
        fp_rf_we_o    = 1'b0;
        fp_rf_waddr_o = 5'd0;
        fp_rf_wdata_o = '0;
        if (any_gnt) begin
            if (sel_fp) begin
                fp_rf_we_o    = 1'b1;
                fp_rf_waddr_o = sel_addr;
                fp_rf_wdata_o = sel_data;
            end else if (sel_addr != 5'd0) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = sel_addr;
                rf_wdata_o = sel_data[31:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_valid_q <= 1'b0;
            skid_fp_q    <= 1'b0;
            skid_waddr_q <= 5'd0;
            skid_wdata_q <= '0;
            starve_cnt_q <= 4'd0;
        end else begin
            if (ex_hs && !gnt_ex) begin
                skid_valid_q <= 1'b1;
                skid_fp_q    <= ex_fp_i;
                skid_waddr_q <= ex_waddr_i;
                skid_wdata_q <= ex_wdata_i;
            end else if (skid_valid_q && gnt_ex) begin
                skid_valid_q <= 1'b0;
            end
            if (!mc_valid_i || gnt_mc) begin
                starve_cnt_q <= 4'd0;
            end else if (!at_limit) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_wb_port_arbiter.sv
// Scoreboard bench for ibex_wb_port_arbiter: directed scenarios then random traffic against a queue-based reference model.
module tb_ibex_wb_port_arbiter;

    localparam int FW  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lsu_valid = 1'b0, lsu_fp = 1'b0;
    logic [4:0]    lsu_waddr = '0;
    logic [31:0]   lsu_wdata = '0;
    logic          ex_valid = 1'b0, ex_fp = 1'b0, ex_ready;
    logic [4:0]    ex_waddr = '0;
    logic [FW-1:0] ex_wdata = '0;
    logic          mc_valid = 1'b0, mc_fp = 1'b0, mc_ready;
    logic [4:0]    mc_waddr = '0;
    logic [FW-1:0] mc_wdata = '0;
    logic          rf_we, fp_rf_we, pending, pending_fp, perf_stall;
    logic [4:0]    rf_waddr, fp_rf_waddr, pending_waddr;
    logic [31:0]   rf_wdata;
    logic [FW-1:0] fp_rf_wdata;

    ibex_wb_port_arbiter #(.FPU_WIDTH(FW), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_valid_i(lsu_valid), .lsu_fp_i(lsu_fp), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_fp_i(ex_fp), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .mc_valid_i(mc_valid), .mc_ready_o(mc_ready), .mc_fp_i(mc_fp), .mc_waddr_i(mc_waddr), .mc_wdata_i(mc_wdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .fp_rf_we_o(fp_rf_we), .fp_rf_waddr_o(fp_rf_waddr), .fp_rf_wdata_o(fp_rf_wdata),
        .pending_o(pending), .pending_fp_o(pending_fp), .pending_waddr_o(pending_waddr),
        .perf_stall_o(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; bit fp; logic [4:0] addr; logic [63:0] data; } wr_t;
    typedef struct { int cyc; bit ex_rdy; bit mc_rdy; bit pend; bit pend_fp; logic [4:0] pend_addr;
                     bit stall; bit we; bit fp_we; } st_t;
    typedef struct { bit fp; logic [4:0] addr; logic [63:0] data; } ent_t;

    wr_t  wq[$];
    st_t  sq[$];
    ent_t m_skid[$];
    int   m_cnt = 0;
    int   checks = 0, failures = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    bit   ex_hold = 1'b0, mc_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: who owns the write slot this cycle, from the priority rules directly.
    task automatic model_step(output bit ex_acc, output bit mc_acc);
        st_t  s;
        wr_t  w;
        ent_t cand;
        ent_t wr_ent;
        bit   cv;
        int   win;
        int   nreq;
        s = '{cyc, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        ex_acc = 1'b0;
        mc_acc = 1'b0;
        if (!rst_n) begin
            m_skid.delete();
            m_cnt = 0;
            sq.push_back(s);
            return;
        end
        s.ex_rdy = (m_skid.size() == 0);
        s.pend   = !s.ex_rdy;
        if (s.pend) begin
            s.pend_fp   = m_skid[0].fp;
            s.pend_addr = m_skid[0].addr;
        end
        cv = 1'b0;
        cand = '{1'b0, 5'd0, 64'd0};
        if (m_skid.size() != 0) begin
            cand = m_skid[0];
            cv = 1'b1;
        end else if (ex_valid) begin
            cand = '{ex_fp, ex_waddr, ex_wdata};
            cv = 1'b1;
        end
        nreq = int'(lsu_valid) + int'(cv) + int'(mc_valid);
        s.stall = (nreq >= 2);
        if (lsu_valid) win = 1;
        else if (cv && !(m_cnt == LIM && mc_valid)) win = 2;
        else if (mc_valid) win = 3;
        else win = 0;
        s.mc_rdy = (win == 3);
        wr_ent = '{1'b0, 5'd0, 64'd0};
        if (win == 1) wr_ent = '{lsu_fp, lsu_waddr, lsu_fp ? {32'hFFFF_FFFF, lsu_wdata} : {32'd0, lsu_wdata}};
        if (win == 2) wr_ent = cand;
        if (win == 3) wr_ent = '{mc_fp, mc_waddr, mc_wdata};
        if (win != 0) begin
            if (wr_ent.fp) begin
                s.fp_we = 1'b1;
                w = '{cyc, 1'b1, wr_ent.addr, wr_ent.data};
                wq.push_back(w);
            end else if (wr_ent.addr != 5'd0) begin
                s.we = 1'b1;
                w = '{cyc, 1'b0, wr_ent.addr, {32'd0, wr_ent.data[31:0]}};
                wq.push_back(w);
            end
        end
        sq.push_back(s);
        ex_acc = ex_valid && s.ex_rdy;
        if (win == 2 && !s.ex_rdy) void'(m_skid.pop_front());
        if (ex_acc && win != 2) m_skid.push_back('{ex_fp, ex_waddr, ex_wdata});
        if (!mc_valid || win == 3) m_cnt = 0;
        else if (m_cnt < LIM) m_cnt++;
        mc_acc = (win == 3);
    endtask

    task automatic cyc_go(input bit r, input bit lv, input bit lf, input logic [4:0] la, input logic [31:0] ld,
                          input bit ev, input bit ef, input logic [4:0] ea, input logic [63:0] ed,
                          input bit mv, input bit mf, input logic [4:0] ma, input logic [63:0] md);
        bit ex_acc, mc_acc;
        @(posedge clk);
        #1;
        rst_n = r;
        lsu_valid = lv; lsu_fp = lf; lsu_waddr = la; lsu_wdata = ld;
        if (!ex_hold) begin ex_valid = ev; ex_fp = ef; ex_waddr = ea; ex_wdata = ed; end
        if (!mc_hold) begin mc_valid = mv; mc_fp = mf; mc_waddr = ma; mc_wdata = md; end
        model_step(ex_acc, mc_acc);
        ex_hold = r && ex_valid && !ex_acc;
        mc_hold = r && mc_valid && !mc_acc;
        if (!r) begin
            #1;
            chk("rst_pending_async", pending, 0);
            chk("rst_no_write", rf_we | fp_rf_we, 0);
        end
    endtask

    task automatic idle();
        cyc_go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle pops one status record, and a write record whenever the DUT writes.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (done) break;
            if (sq.size() == 0) continue;
            s = sq.pop_front();
            chk("ex_ready", ex_ready, s.ex_rdy);
            chk("mc_ready", mc_ready, s.mc_rdy);
            chk("pending", pending, s.pend);
            chk("pending_fp", pending_fp, s.pend_fp);
            chk("pending_waddr", pending_waddr, s.pend_addr);
            chk("perf_stall", perf_stall, s.stall);
            chk("rf_we", rf_we, s.we);
            chk("fp_rf_we", fp_rf_we, s.fp_we);
            if (rf_we || fp_rf_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write cyc=%0d got=1 want=0", cyc);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_is_fp", fp_rf_we, w.fp);
                    if (w.fp) begin
                        chk("fp_waddr", fp_rf_waddr, w.addr);
                        chk("fp_wdata", fp_rf_wdata, w.data);
                        chk("int_bus_idle", {rf_waddr, rf_wdata}, 0);
                    end else begin
                        chk("int_waddr", rf_waddr, w.addr);
                        chk("int_wdata", rf_wdata, w.data);
                        chk("fp_bus_idle", {fp_rf_waddr, fp_rf_wdata}, 0);
                    end
                end
            end else begin
                chk("idle_buses", {rf_waddr, rf_wdata, fp_rf_waddr, fp_rf_wdata}, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then idle.
        repeat (3) cyc_go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Single integer EX write, zero latency.
        cyc_go(1, 0, 0, 0, 0, 1, 0, 5'd5, 64'h1234, 0, 0, 0, 0);
        #1;
        chk("ex_direct_we", rf_we, 1);
        chk("ex_direct_addr", rf_waddr, 5);
        chk("ex_direct_data", rf_wdata, 32'h1234);
        idle();
        // LSU and EX collide: EX goes to the skid and drains next cycle.
        cyc_go(1, 1, 0, 5'd3, 32'hAAAA_0003, 1, 0, 5'd7, 64'h7777, 0, 0, 0, 0);
        idle();
        #1;
        chk("skid_drain_addr", rf_waddr, 7);
        idle();
        // FP load NaN-boxing.
        cyc_go(1, 1, 1, 5'd9, 32'h3F80_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nanbox_data", fp_rf_wdata, 64'hFFFF_FFFF_3F80_0000);
        chk("nanbox_no_int", rf_we, 0);
        idle();
        // Starvation: MC forced through on the fifth contended cycle.
        for (int i = 0; i < 8; i++) begin
            cyc_go(1, 0, 0, 0, 0, 1, 0, 5'(i + 1), 64'(32'h100 + i), (i == 0), 1, 5'd12, 64'hDEAD_BEEF_0000_0012);
            #1;
            chk("starve_mc_ready", mc_ready, (i == 4));
        end
        repeat (2) idle();
        // Integer write to x0 is consumed without a write.
        cyc_go(1, 0, 0, 0, 0, 1, 0, 5'd0, 64'h5555, 0, 0, 0, 0);
        #1;
        chk("x0_no_we", rf_we, 0);
        chk("x0_ready", ex_ready, 1);
        idle();
        // Fill the skid, then reset mid-operation.
        cyc_go(1, 1, 0, 5'd4, 32'h44, 1, 1, 5'd8, 64'h88, 0, 0, 0, 0);
        cyc_go(0, 1, 0, 5'd4, 32'h44, 1, 0, 5'd9, 64'h99, 1, 0, 5'd10, 64'h10);
        cyc_go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc_go(1, ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), $urandom,
                   ($urandom_range(0, 9) < 6), 1'($urandom), 5'($urandom), {$urandom, $urandom},
                   ($urandom_range(0, 9) < 4), 1'($urandom), 5'($urandom), {$urandom, $urandom});
        end
        repeat (3) idle();
        @(negedge clk);
        #1;
        done = 1'b1;
        chk("status_queue_drained", sq.size(), 0);
        chk("write_queue_drained", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
